instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the main decode Controller.
- Holds the PC, requests 32-bit instructions from instruction memory over a ready-qualified interface, and presents one instruction at a time with a valid/ready handshake to decode.
- Decode consumes instr[6:0] as the Controller opcode.
- Accepts the branch redirect produced by the datapath (Controller branch AND ALU zero), discarding any in-flight or held instruction.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  XLEN  fetch address (always equals internal pc)
imem_ready  input  1  imem_rdata valid for the imem_addr presented this cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  instruction held for decode
instr_pc  output  XLEN  address of instr
instr_valid  output  1  instr/instr_pc valid for decode
decode_ready  input  1  decode accepts instr this cycle
branch_taken  input  1  redirect request (single-cycle pulse)
branch_target  input  XLEN  redirect address
misaligned  output  1  sticky: a redirect target had [1:0] != 0
fetch_count  output  32  number of instructions accepted by decode

Behaviour:
- One clock; reset is asynchronous and active-high (ports clock, reset).
- Reset values:
  - pc = RESET_PC; state = REQ
  - instr = 32'h00000013 (NOP); instr_pc = 0; instr_valid = 0
  - misaligned = 0; fetch_count = 0
- imem_req = (state == REQ), decoded from the state register only; no input-to-imem_req combinational path. imem_addr = pc.
- FSM states REQ and HOLD:
  - REQ, imem_ready=0: stay; pc stable.
  - REQ, imem_ready=1: instr <= imem_rdata; instr_pc <= pc; instr_valid <= 1; pc <= pc+4; go HOLD.
  - HOLD, decode_ready=0: stay; instr, instr_pc and instr_valid must not change.
  - HOLD, decode_ready=1: instr_valid <= 0; fetch_count++; go REQ. Next request starts the following cycle, so minimum 2 cycles per instruction.
- Latency: a memory response in cycle N gives instr_valid=1 in cycle N+1.
- pc+4 wraps modulo 2^XLEN. fetch_count wraps modulo 2^32.
- Priority (highest first): reset > branch_taken > imem_ready / decode_ready.
- branch_taken=1 in any state:
  - pc <= {branch_target[XLEN-1:2], 2'b00}; instr_valid <= 0; state <= REQ.
  - A same-cycle imem_ready response is discarded.
  - A same-cycle decode_ready handshake in HOLD still counts: fetch_count++, because decode consumed the instruction.
- If branch_target[1:0] != 0 when branch_taken=1: misaligned <= 1, cleared only by reset.
- branch_taken held high for consecutive cycles: each cycle reloads pc; no fetch completes until it drops.
- Reset asserted mid-request or mid-hold: all state returns to reset values immediately. The memory response is ignored.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants OP_RTYPE 7'b0110011, OP_LD 7'b0000011, OP_SD 7'b0100011, OP_BEQ 7'b1100011
  - INSTR_NOP 32'h00000013
  - fetch_state_t enum {REQ, HOLD}
  - XLEN default
- One sub-module, program_counter: holds pc; async reset to RESET_PC; load(target) / increment / hold controls; implements wrap and alignment masking.

Test Plan:
- Reset, then imem_ready=1 every cycle with rdata=0x00000033, decode_ready=1 -> imem_addr 0,4,8 on alternate cycles; instr_valid pulses with instr_pc 0,4,8; fetch_count=3 after three handshakes.
- imem_ready delayed 3 cycles at pc=0x10 -> imem_req and imem_addr=0x10 stable for 3 cycles; instr_valid rises the cycle after the response.
- In HOLD, decode_ready=0 for 4 cycles -> instr, instr_pc and instr_valid unchanged, imem_req=0; release -> fetch_count+1, next imem_addr = instr_pc+4.
- branch_taken with target 0x100 in the same cycle as imem_ready at pc=0x20 -> response discarded, instr_valid stays 0, next imem_addr=0x100.
- branch_taken target 0x102 -> pc=0x100, misaligned=1 and stays 1 until reset; pc=2^64-4 with a fetch -> next pc 0x0.
- Reset asserted mid-HOLD -> instr_valid=0, instr=NOP, pc=RESET_PC, fetch_count=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch/decode slice of the core.
//   DEFAULT_XLEN  : default address / PC width
//   OP_*          : Controller opcode values (instr[6:0]) consumed by decode
//   INSTR_NOP     : addi x0,x0,0 -- the instruction register's idle value
//   fetch_state_t : fetch FSM states (REQ = memory request outstanding,
//                   HOLD = instruction presented to decode)
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int DEFAULT_XLEN = 64;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the two handshakes of the fetch stage:
//   instruction memory : imem_req, imem_addr (fetch -> mem),
//                        imem_ready, imem_rdata (mem -> fetch)
//   decode             : instr, instr_pc, instr_valid (fetch -> decode),
//                        decode_ready (decode -> fetch)
// master = fetch stage, slave = memory + decode side.
// -----------------------------------------------------------------------------
interface instruction_fetch_if
    import riscv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            decode_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  decode_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output decode_ready
    );

endinterface

// File: rtl/instruction_fetch_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Holds the fetch PC.
//   clock, reset : clock, asynchronous active-high reset (pc <= RESET_PC)
//   load, target : redirect; target is forced to a 4-byte boundary
//   incr         : advance to the next sequential word (wraps mod 2^XLEN)
//   pc           : current PC
// load has priority over incr; with neither asserted the PC holds.
// RESET_PC is expected to be 4-byte aligned.
// -----------------------------------------------------------------------------
module program_counter
    import riscv_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            incr,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = target & ALIGN_MASK;
        end else if (incr) begin
            // Natural XLEN-bit overflow gives the required wrap to 0.
            pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage feeding the decode Controller.
//   clock, reset   : clock, asynchronous active-high reset
//   bus (master)   : imem request/response and decode valid/ready handshake
//   branch_taken   : single-cycle redirect pulse (Controller branch & ALU zero)
//   branch_target  : redirect address (low two bits dropped)
//   misaligned     : sticky flag, a redirect target was not word aligned
//   fetch_count    : instructions accepted by decode (wraps mod 2^32)
// Two-state FSM: REQ requests imem_addr=pc until imem_ready, HOLD presents
// the captured word until decode_ready. A redirect overrides both and drops
// whatever instruction is in flight or held.
// -----------------------------------------------------------------------------
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    instruction_fetch_if.master bus,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_target,
    output logic                misaligned,
    output logic [31:0]         fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            misaligned_q, misaligned_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic [XLEN-1:0] pc;
    logic            fetch_accept;
    logic            decode_handshake;

    // A response arriving together with a redirect belongs to the old path
    // and is dropped. A decode handshake is still counted under a redirect,
    // since decode really did consume that instruction.
    assign fetch_accept     = (state_q == REQ)  && bus.imem_ready && !branch_taken;
    assign decode_handshake = (state_q == HOLD) && bus.decode_ready;

    program_counter #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock  (clock),
        .reset  (reset),
        .load   (branch_taken),
        .incr   (fetch_accept),
        .target (branch_target),
        .pc     (pc)
    );

    // State register (plus datapath registers sharing the same reset).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= REQ;
            instr_q       <= INSTR_NOP;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = REQ;
        end else begin
            case (state_q)
                REQ:     if (bus.imem_ready)   state_d = HOLD;
                HOLD:    if (bus.decode_ready) state_d = REQ;
                default: state_d = REQ;
            endcase
        end
    end

    // Datapath next values.
    always_comb begin
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (fetch_accept) begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
        end else if (branch_taken || decode_handshake) begin
            // instr/instr_pc keep their last value; only valid drops.
            instr_valid_d = 1'b0;
        end
        fetch_count_d = fetch_count_q + {31'd0, decode_handshake};
        misaligned_d  = misaligned_q | (branch_taken & (|branch_target[1:0]));
    end

    // Outputs: imem_req depends on the state register only.
    always_comb begin
        bus.imem_req    = (state_q == REQ);
        bus.imem_addr   = pc;
        bus.instr       = instr_q;
        bus.instr_pc    = instr_pc_q;
        bus.instr_valid = instr_valid_q;
        misaligned      = misaligned_q;
        fetch_count     = fetch_count_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch. A behavioural model of the
// fetch stage tracks expected pc / state / count; every accepted memory
// response is pushed to a scoreboard and popped when decode takes it.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int XLEN = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clock;
    logic            reset;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            misaligned;
    logic [31:0]     fetch_count;

    instruction_fetch_if #(.XLEN(XLEN)) bus ();

    instruction_fetch #(
        .XLEN     (XLEN),
        .RESET_PC ('0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .misaligned    (misaligned),
        .fetch_count   (fetch_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0]     word;
        logic [XLEN-1:0] pc;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state.
    logic            m_hold;
    logic [XLEN-1:0] m_pc;
    logic            m_valid;
    logic [31:0]     m_count;
    logic            m_mis;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold  = 1'b0;
        m_pc    = '0;
        m_valid = 1'b0;
        m_count = '0;
        m_mis   = 1'b0;
        sb_q.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, check the registered
    // outputs against the model, advance the model, then wait a full cycle.
    task automatic step(input logic rdy, input logic [31:0] rdata, input logic dr,
                        input logic br, input logic [XLEN-1:0] tgt);
        sb_entry_t e;
        logic hs;
        logic acc;
        bus.imem_ready   = rdy;
        bus.imem_rdata   = rdata;
        bus.decode_ready = dr;
        branch_taken     = br;
        branch_target    = tgt;
        #1;
        check_val("imem_req",    {63'd0, bus.imem_req}, {63'd0, ~m_hold});
        check_val("imem_addr",   bus.imem_addr, m_pc);
        check_val("instr_valid", {63'd0, bus.instr_valid}, {63'd0, m_valid});
        check_val("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
        check_val("misaligned",  {63'd0, misaligned}, {63'd0, m_mis});
        if (m_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got valid instr %h, expected no entry", bus.instr);
            end else begin
                e = sb_q[0];
                check_val("instr",    {32'd0, bus.instr}, {32'd0, e.word});
                check_val("instr_pc", bus.instr_pc, e.pc);
            end
        end

        hs  = m_hold && dr;
        acc = !m_hold && rdy && !br;
        if (m_hold && (hs || br) && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (hs) begin
                $display("decode accept pc=%h instr=%h", e.pc, e.word);
            end
        end
        if (hs) m_count = m_count + 32'd1;
        if (br) begin
            m_pc    = {tgt[XLEN-1:2], 2'b00};
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            m_valid = 1'b0;
            m_hold  = 1'b0;
        end else if (acc) begin
            e.word  = rdata;
            e.pc    = m_pc;
            sb_q.push_back(e);
            m_pc    = m_pc + 64'd4;
            m_valid = 1'b1;
            m_hold  = 1'b1;
        end else if (hs) begin
            m_valid = 1'b0;
            m_hold  = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [XLEN-1:0] big_pc;
        reset            = 1'b1;
        bus.imem_ready   = 1'b0;
        bus.imem_rdata   = '0;
        bus.decode_ready = 1'b0;
        branch_taken     = 1'b0;
        branch_target    = '0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state.
        check_val("rst_instr",       {32'd0, bus.instr}, {32'd0, NOP});
        check_val("rst_instr_pc",    bus.instr_pc, 64'd0);
        check_val("rst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("rst_imem_req",    {63'd0, bus.imem_req}, 64'd1);
        check_val("rst_imem_addr",   bus.imem_addr, 64'd0);
        check_val("rst_fetch_count", {32'd0, fetch_count}, 64'd0);
        check_val("rst_misaligned",  {63'd0, misaligned}, 64'd0);
        reset = 1'b0;

        // Back-to-back fetches, decode always ready: pcs 0,4,8.
        repeat (6) step(1'b1, 32'h0000_0033, 1'b1, 1'b0, '0);
        check_val("count_after_3", {32'd0, fetch_count}, 64'd3);

        // One more fetch to reach pc=0x10, then delay the response 3 cycles.
        repeat (2) step(1'b1, 32'h0000_0003, 1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 32'hBAD0_0000, 1'b1, 1'b0, '0);
        step(1'b1, 32'h0000_0023, 1'b0, 1'b0, '0);

        // Decode stalls 4 cycles in HOLD, then releases.
        repeat (4) step(1'b0, 32'hBAD0_0001, 1'b0, 1'b0, '0);
        step(1'b0, 32'h0, 1'b1, 1'b0, '0);
        check_val("addr_after_hold", bus.imem_addr, 64'h14);

        // Redirect to 0x20, then a redirect colliding with a response.
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h20);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 64'h100);
        check_val("discard_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("redirect_addr", bus.imem_addr, 64'h100);

        // Redirect in HOLD together with a decode handshake still counts.
        step(1'b1, 32'h0000_0063, 1'b0, 1'b0, '0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 64'h200);

        // Misaligned redirect, then branch held high for consecutive cycles.
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h102);
        check_val("mis_addr", bus.imem_addr, 64'h100);
        step(1'b1, 32'h1111_1111, 1'b1, 1'b1, 64'h40);
        step(1'b1, 32'h2222_2222, 1'b1, 1'b1, 64'h44);

        // PC wrap at the top of the address space.
        big_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1'b0, 32'h0, 1'b0, 1'b1, big_pc);
        step(1'b1, 32'h0000_0033, 1'b0, 1'b0, '0);
        check_val("wrap_addr", bus.imem_addr, 64'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, {$urandom, $urandom});
        end

        // Reset mid-HOLD takes effect before the next clock edge.
        while (!m_hold) step(1'b1, 32'h0000_0033, 1'b0, 1'b0, '0);
        reset = 1'b1;
        #1;
        check_val("arst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        check_val("arst_instr",       {32'd0, bus.instr}, {32'd0, NOP});
        check_val("arst_imem_addr",   bus.imem_addr, 64'd0);
        check_val("arst_fetch_count", {32'd0, fetch_count}, 64'd0);
        check_val("arst_misaligned",  {63'd0, misaligned}, 64'd0);
        check_val("arst_imem_req",    {63'd0, bus.imem_req}, 64'd1);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (4) step(1'b1, 32'h0000_0013, 1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
